jackpot_spin: RTL and testbench

Consumer of the divided slow clock in the jackpot game. It treats the slow clock as data and synchronizes it into the fast clkIN domain. Each rising edge of the slow clock becomes a one-cycle step, and each step rotates a one-hot LED pattern. The block also watches player switches and declares a win when the switch that rises matches the lit LED. It sits between the clock divider and the board LEDs/switches.

---
 rtl/jackpot_spin.sv | 108 ++++++++++
 tb/tb_jackpot_spin.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/jackpot_spin.sv
// Rotating one-hot LED game: the slow tick is synchronized as data and advances the
// lit LED; a single switch rising under the lit LED scores a win.
module jackpot_spin #(
  parameter int LED_N = 4,
  parameter int CNT_W = 8
) (
  input  logic             clkIN,
  input  logic             rst_n,
  input  logic             tickIN,
  input  logic [LED_N-1:0] sw,
  output logic [LED_N-1:0] leds,
  output logic             win,
  output logic             step,
  output logic [CNT_W-1:0] win_count
);

  typedef enum logic {SPIN, WIN} state_t;

  state_t           r_state;
  logic             r_tick_s1, r_tick_s2, r_tick_prev;
  logic [LED_N-1:0] r_sw_s1, r_sw_s2, r_sw_prev;
  logic [LED_N-1:0] r_leds;
  logic             r_win;
  logic [CNT_W-1:0] r_win_count;

  logic             w_step;
  logic [LED_N-1:0] w_sw_rise;
  logic             w_rise_onehot;
  logic             w_match;
  logic             w_sw_idle;

  always_ff @(posedge clkIN or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_s1   <= 1'b0;
      r_tick_s2   <= 1'b0;
      r_tick_prev <= 1'b0;
    end else begin
      r_tick_s1   <= tickIN;
      r_tick_s2   <= r_tick_s1;
      r_tick_prev <= r_tick_s2;
    end
  end

  generate
    for (genvar gi = 0; gi < LED_N; gi++) begin : g_sw_sync
      always_ff @(posedge clkIN or negedge rst_n) begin
        if (!rst_n) begin
          r_sw_s1[gi]   <= 1'b0;
          r_sw_s2[gi]   <= 1'b0;
          r_sw_prev[gi] <= 1'b0;
        end else begin
          r_sw_s1[gi]   <= sw[gi];
          r_sw_s2[gi]   <= r_sw_s1[gi];
          r_sw_prev[gi] <= r_sw_s2[gi];
        end
      end
    end
  endgenerate

  // A rise only scores when exactly one switch rose and it is the lit one.
  assign w_step        = r_tick_s2 & ~r_tick_prev;
  assign w_sw_rise     = r_sw_s2 & ~r_sw_prev;
  assign w_rise_onehot = (w_sw_rise != '0) &&
                         ((w_sw_rise & (w_sw_rise - {{(LED_N-1){1'b0}}, 1'b1})) == '0);
  assign w_match       = w_rise_onehot && (w_sw_rise == r_leds);
  assign w_sw_idle     = (r_sw_s2 == '0);

  always_ff @(posedge clkIN or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SPIN;
      r_leds      <= {{(LED_N-1){1'b0}}, 1'b1};
      r_win       <= 1'b0;
      r_win_count <= '0;
    end else begin
      case (r_state)
        SPIN: begin
          if (w_match) begin
            r_state <= WIN;
            r_leds  <= '1;
            r_win   <= 1'b1;
            if (r_win_count != '1)
              r_win_count <= r_win_count + 1'b1;
          end else if (w_step) begin
            r_leds <= {r_leds[LED_N-2:0], r_leds[LED_N-1]};
          end
        end
        WIN: begin
          if (w_sw_idle && w_step) begin
            r_state <= SPIN;
            r_leds  <= {{(LED_N-1){1'b0}}, 1'b1};
            r_win   <= 1'b0;
          end
        end
        default: begin
          r_state <= SPIN;
          r_leds  <= {{(LED_N-1){1'b0}}, 1'b1};
          r_win   <= 1'b0;
        end
      endcase
    end
  end

  assign leds      = r_leds;
  assign win       = r_win;
  assign step      = w_step;
  assign win_count = r_win_count;

endmodule

// File: tb/tb_jackpot_spin.sv
// Scoreboard bench for jackpot_spin: a behavioural model predicts each cycle's outputs
// into a queue, and an independent monitor pops and compares after every clock edge.
module tb_jackpot_spin;

  localparam int N  = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          tickIN = 1'b0;
  logic [N-1:0]  sw = '0;
  logic [N-1:0]  leds;
  logic          win;
  logic          step;
  logic [CW-1:0] win_count;

  jackpot_spin #(.LED_N(N), .CNT_W(CW)) dut (
    .clkIN(clk), .rst_n(rst_n), .tickIN(tickIN), .sw(sw),
    .leds(leds), .win(win), .step(step), .win_count(win_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  leds;
    logic          win;
    logic          step;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;

  // Model: lit LED as a position, inputs as a history of clock-sampled values (age 0 newest).
  int           m_pos = 0;
  bit           m_win = 0;
  int           m_cnt = 0;
  bit           tick_hist[3];
  logic [N-1:0] sw_hist[3];

  task automatic model_edge();
    exp_t         e;
    bit           st;
    logic [N-1:0] rise;
    if (!rst_n) begin
      m_pos = 0; m_win = 0; m_cnt = 0;
      for (int i = 0; i < 3; i++) begin tick_hist[i] = 0; sw_hist[i] = '0; end
    end else begin
      // The rising edge that becomes visible two samples late is what acts at this edge.
      st   = tick_hist[1] && !tick_hist[2];
      rise = sw_hist[1] & ~sw_hist[2];
      if (!m_win) begin
        if ($countones(rise) == 1 && rise == N'(1 << m_pos)) begin
          m_win = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else if (st) begin
          m_pos = (m_pos + 1) % N;
        end
      end else if (sw_hist[1] == '0 && st) begin
        m_win = 0;
        m_pos = 0;
      end
      tick_hist[2] = tick_hist[1]; tick_hist[1] = tick_hist[0]; tick_hist[0] = tickIN;
      sw_hist[2]   = sw_hist[1];   sw_hist[1]   = sw_hist[0];   sw_hist[0]   = sw;
    end
    e.leds = m_win ? '1 : N'(1 << m_pos);
    e.win  = m_win;
    e.step = tick_hist[1] && !tick_hist[2];
    e.cnt  = CW'(m_cnt);
    sbq.push_back(e);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin tick_hist[i] = 0; sw_hist[i] = '0; end
    forever begin
      @(posedge clk);
      model_edge();
    end
  end

  // Monitor
  initial begin
    exp_t e;
    bit   prev_win = 0;
    forever begin
      @(posedge clk);
      #1;
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = sbq.pop_front();
        if (leds !== e.leds || win !== e.win || step !== e.step || win_count !== e.cnt) begin
          errors++;
          $display("FAIL cycle t=%0t leds=%b/%b win=%b/%b step=%b/%b cnt=%0d/%0d (actual/required)",
                   $time, leds, e.leds, win, e.win, step, e.step, win_count, e.cnt);
        end else if (e.step || e.win != prev_win) begin
          $display("txn t=%0t leds=%b win=%b step=%b cnt=%0d", $time, leds, win, step, win_count);
        end
        prev_win = e.win;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    tickIN = 1'b1; cyc(8);
    tickIN = 1'b0; cyc(8);
  endtask

  task automatic pulse_until_pos0();
    for (int i = 0; i < 2 * N && !(m_pos == 0 && !m_win); i++) pulse();
  endtask

  task automatic check_now(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    int phase;
    // Reset
    rst_n = 1'b0; cyc(5);
    rst_n = 1'b1; cyc(2);

    // Rotation and wrap
    for (int i = 0; i < 5; i++) pulse();
    pulse();                               // leds now 0100
    // Correct win on the lit LED
    sw = 4'b0100; cyc(6);
    sw = '0; cyc(4);
    pulse();

    // Wrong switch, then two switches at once
    pulse_until_pos0();
    sw = 4'b1000; cyc(5);
    sw = '0; cyc(3);
    sw = 4'b0011; cyc(5);
    sw = '0; cyc(3);
    pulse();

    // Step and matching rise together: the win takes priority
    pulse_until_pos0();
    tickIN = 1'b1; sw = 4'b0001; cyc(8);
    tickIN = 1'b0; cyc(8);
    pulse();                               // switch still high: WIN holds
    sw = '0; cyc(4);
    pulse();

    // Drive the counter into saturation
    for (int w = 0; w < 4; w++) begin
      sw = N'(1 << m_pos); cyc(5);
      sw = '0; cyc(3);
      pulse();
    end
    sw = N'(1 << m_pos); cyc(6);           // ends in WIN with the counter saturated

    // Asynchronous reset mid-WIN, away from any clock edge
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_now("async_rst_leds", 32'(leds), 32'(1));
    check_now("async_rst_win", 32'(win), 32'(0));
    check_now("async_rst_step", 32'(step), 32'(0));
    check_now("async_rst_cnt", 32'(win_count), 32'(0));
    sw = '0;
    cyc(3);
    rst_n = 1'b1;

    // Randomized play
    phase = 3;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (--phase == 0) begin
        tickIN = ~tickIN;
        phase  = $urandom_range(3, 10);
      end
      if ($urandom_range(0, 5) == 0) begin
        case ($urandom_range(0, 3))
          0, 1:    sw = '0;
          2:       sw = N'(1 << m_pos);
          default: sw = N'($urandom);
        endcase
      end
    end
    cyc(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
